// File: rtl/fir_channel_arbiter.sv
// fir_channel_arbiter
// Round-robin arbiter that shares one FIR datapath among NUM_CH sample
// requesters. Each issued sample is tagged with its channel index in an
// in-order tag FIFO; FIR outputs pop the head tag and are routed back to
// the channel that issued the matching input sample.

module fir_channel_arbiter #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   iv_req_data,
  input  logic [NUM_CH-1:0]              iv_req_valid,
  output logic [NUM_CH-1:0]              ov_req_ready,
  output logic [DATA_WIDTH-1:0]          ov_fir_din,
  output logic                           o_fir_din_valid,
  input  logic [DATA_WIDTH-1:0]          iv_fir_dout,
  input  logic                           i_fir_dout_valid,
  output logic [DATA_WIDTH-1:0]          ov_ch_dout,
  output logic [NUM_CH-1:0]              ov_ch_dout_valid,
  output logic [$clog2(NUM_CH)-1:0]      ov_ch_id,
  output logic                           o_tag_err,
  output logic                           o_busy
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  // Arbitration state
  logic [CH_W-1:0]       last_grant;

  // Tag FIFO state
  logic [CH_W-1:0]       tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;

  // Combinational control
  logic                  full;
  logic                  grant_found;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       cand_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  push;
  logic                  pop;
  logic [CH_W-1:0]       head_tag;
  logic [NUM_CH-1:0]     head_onehot;

  // Grants are blocked on the registered count, so a pop in the same cycle
  // never frees a slot until the following cycle.
  assign full = (count == CNT_FULL);

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    if (i_en && !full) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cand_idx = CH_W'((32'(last_grant) + 32'd1 + i) % NUM_CH);
        if (!grant_found && iv_req_valid[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // One-hot ready for the granted channel only
  always_comb begin
    ov_req_ready = '0;
    if (grant_found) begin
      ov_req_ready[grant_idx] = 1'b1;
    end
  end

  // Select the granted channel's sample
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_idx) begin
        grant_data = iv_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The grant already requires the request to be valid, so grant == accept.
  assign push     = grant_found;
  assign pop      = i_fir_dout_valid && (count != '0);
  assign head_tag = tag_mem[rd_ptr];

  // Decode the head tag into the per-channel output strobe
  always_comb begin
    head_onehot           = '0;
    head_onehot[head_tag] = 1'b1;
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Tag storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  // FIFO pointers, occupancy and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= LAST_CH;
    end else begin
      count <= count_nxt;
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIR input register: data holds its last value when nothing is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_fir_din      <= '0;
      o_fir_din_valid <= 1'b0;
    end else begin
      o_fir_din_valid <= push;
      if (push) begin
        ov_fir_din <= grant_data;
      end
    end
  end

  // Return routing; independent of i_en so in-flight samples always drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_ch_dout       <= '0;
      ov_ch_dout_valid <= '0;
      ov_ch_id         <= '0;
    end else begin
      ov_ch_dout_valid <= '0;
      if (pop) begin
        ov_ch_dout       <= iv_fir_dout;
        ov_ch_dout_valid <= head_onehot;
        ov_ch_id         <= head_tag;
      end
    end
  end

  // Sticky underflow flag and registered busy status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tag_err <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      if (i_fir_dout_valid && (count == '0)) begin
        o_tag_err <= 1'b1;
      end
      o_busy <= (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// Directed testbench for fir_channel_arbiter (4 channels, 24-bit, depth 8).
module tb_fir_channel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [95:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] fir_din;
  logic        fir_din_valid;
  logic [23:0] fir_dout;
  logic        fir_dout_valid;
  logic [23:0] ch_dout;
  logic [3:0]  ch_dout_valid;
  logic [1:0]  ch_id;
  logic        tag_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned exp_q[$];

  fir_channel_arbiter #(.DATA_WIDTH(24), .NUM_CH(4), .TAG_DEPTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
    .iv_req_data(req_data), .iv_req_valid(req_valid), .ov_req_ready(req_ready),
    .ov_fir_din(fir_din), .o_fir_din_valid(fir_din_valid),
    .iv_fir_dout(fir_dout), .i_fir_dout_valid(fir_dout_valid),
    .ov_ch_dout(ch_dout), .ov_ch_dout_valid(ch_dout_valid), .ov_ch_id(ch_id),
    .o_tag_err(tag_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0;
    fir_dout = '0; fir_dout_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_data = '0;
    fir_dout = '0; fir_dout_valid = 1'b0;
    tick(); tick();
    n_checks++; if (fir_din !== 24'h0) begin n_fail++; $display("FAIL rst_fir_din got %h exp 0", fir_din); end
    n_checks++; if (fir_din_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fir_din_valid got %b exp 0", fir_din_valid); end
    n_checks++; if (ch_dout !== 24'h0) begin n_fail++; $display("FAIL rst_ch_dout got %h exp 0", ch_dout); end
    n_checks++; if (ch_dout_valid !== 4'h0) begin n_fail++; $display("FAIL rst_ch_dout_valid got %b exp 0", ch_dout_valid); end
    n_checks++; if (ch_id !== 2'd0) begin n_fail++; $display("FAIL rst_ch_id got %0d exp 0", ch_id); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL rst_tag_err got %b exp 0", tag_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    en = 1'b1; req_valid = 4'hF; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_priority got %b exp 0001", req_ready); end
    rst_n = 1'b1; req_valid = '0; en = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    en = 1'b1; req_data[2*24 +: 24] = 24'h000123; req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick(); req_valid = '0;
    n_checks++; if (fir_din_valid !== 1'b1) begin n_fail++; $display("FAIL single_din_valid got %b exp 1", fir_din_valid); end
    n_checks++; if (fir_din !== 24'h000123) begin n_fail++; $display("FAIL single_din got %h exp 000123", fir_din); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy); end
    fir_dout = 24'h0ABCDE; fir_dout_valid = 1'b1;
    tick(); fir_dout_valid = 1'b0;
    n_checks++; if (fir_din_valid !== 1'b0) begin n_fail++; $display("FAIL single_din_valid_drop got %b exp 0", fir_din_valid); end
    n_checks++; if (fir_din !== 24'h000123) begin n_fail++; $display("FAIL single_din_hold got %h exp 000123", fir_din); end
    n_checks++; if (ch_dout_valid !== 4'b0100) begin n_fail++; $display("FAIL single_dout_valid got %b exp 0100", ch_dout_valid); end
    n_checks++; if (ch_id !== 2'd2) begin n_fail++; $display("FAIL single_ch_id got %0d exp 2", ch_id); end
    n_checks++; if (ch_dout !== 24'h0ABCDE) begin n_fail++; $display("FAIL single_dout got %h exp 0abcde", ch_dout); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_clear got %b exp 0", busy); end
    tick();
    n_checks++; if (ch_dout_valid !== 4'b0000) begin n_fail++; $display("FAIL single_dout_pulse got %b exp 0000", ch_dout_valid); end
  endtask

  task automatic test_round_robin();
    logic [23:0] d;
    apply_reset();
    en = 1'b1; req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) req_data[k*24 +: 24] = 24'(32'h1000 * (i + 1) + k);
      #1;
      n_checks++; if (req_ready !== 4'(1 << (i % 4))) begin n_fail++; $display("FAIL rr_ready[%0d] got %b exp %b", i, req_ready, 4'(1 << (i % 4))); end
      tick();
      d = 24'(32'h1000 * (i + 1) + (i % 4));
      n_checks++; if (fir_din_valid !== 1'b1 || fir_din !== d) begin n_fail++; $display("FAIL rr_din[%0d] got %b/%h exp 1/%h", i, fir_din_valid, fir_din, d); end
    end
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_full_ready got %b exp 0000", req_ready); end
    req_valid = '0;
    for (int j = 0; j < 8; j++) begin
      fir_dout = 24'(32'h0F0000 + j); fir_dout_valid = 1'b1;
      tick();
      n_checks++; if (ch_dout_valid !== 4'(1 << (j % 4)) || ch_id !== 2'(j % 4) || ch_dout !== 24'(32'h0F0000 + j)) begin
        n_fail++; $display("FAIL rr_return[%0d] got %b/%0d/%h exp %b/%0d/%h", j, ch_dout_valid, ch_id, ch_dout, 4'(1 << (j % 4)), j % 4, 24'(32'h0F0000 + j));
      end
    end
    fir_dout_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_drained_busy got %b exp 0", busy); end
  endtask

  task automatic test_full_stall_and_wrap();
    int accepts;
    int unsigned nxt;
    int unsigned et;
    logic [3:0] er;
    apply_reset();
    en = 1'b1; req_valid = 4'hF; accepts = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req_ready !== 4'b0000) accepts++;
      tick();
    end
    n_checks++; if (accepts != 8) begin n_fail++; $display("FAIL full_accepts got %0d exp 8", accepts); end
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_ready got %b exp 0000", req_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b exp 1", busy); end
    fir_dout = 24'h0C0001; fir_dout_valid = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_pop_cycle_ready got %b exp 0000", req_ready); end
    tick(); fir_dout_valid = 1'b0;
    n_checks++; if (ch_dout_valid !== 4'b0001 || ch_dout !== 24'h0C0001) begin n_fail++; $display("FAIL full_first_return got %b/%h exp 0001/0c0001", ch_dout_valid, ch_dout); end
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL full_refill_ready got %b exp 0001", req_ready); end
    tick();
    n_checks++; if (fir_din_valid !== 1'b1) begin n_fail++; $display("FAIL full_refill_din_valid got %b exp 1", fir_din_valid); end
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL full_again_ready got %b exp 0000", req_ready); end
    // FIFO now holds tags 1,2,3,0,1,2,3,0 oldest first; next grant is ch1
    exp_q = '{1, 2, 3, 0, 1, 2, 3, 0};
    nxt = 1;
    for (int k = 0; k < 10; k++) begin
      fir_dout = 24'(32'h0D0000 + k); fir_dout_valid = 1'b1; #1;
      er = (k == 0) ? 4'b0000 : 4'(1 << nxt);
      n_checks++; if (req_ready !== er) begin n_fail++; $display("FAIL pp_ready[%0d] got %b exp %b", k, req_ready, er); end
      tick();
      et = exp_q.pop_front();
      if (k != 0) begin exp_q.push_back(nxt); nxt = (nxt + 1) % 4; end
      n_checks++; if (ch_dout_valid !== 4'(1 << et) || ch_id !== 2'(et) || ch_dout !== 24'(32'h0D0000 + k)) begin
        n_fail++; $display("FAIL pp_return[%0d] got %b/%0d/%h exp %b/%0d/%h", k, ch_dout_valid, ch_id, ch_dout, 4'(1 << et), et, 24'(32'h0D0000 + k));
      end
      n_checks++; if (fir_din_valid !== (k != 0)) begin n_fail++; $display("FAIL pp_din_valid[%0d] got %b exp %b", k, fir_din_valid, k != 0); end
    end
    fir_dout_valid = 1'b0; #1;
    n_checks++; if (req_ready !== 4'(1 << nxt)) begin n_fail++; $display("FAIL pp_last_ready got %b exp %b", req_ready, 4'(1 << nxt)); end
    tick(); req_valid = '0;
    exp_q.push_back(nxt);
    for (int j = 0; j < 8; j++) begin
      fir_dout = 24'(32'h0E0000 + j); fir_dout_valid = 1'b1;
      tick();
      et = exp_q.pop_front();
      n_checks++; if (ch_dout_valid !== 4'(1 << et) || ch_id !== 2'(et)) begin n_fail++; $display("FAIL drain_tag[%0d] got %b/%0d exp %b/%0d", j, ch_dout_valid, ch_id, 4'(1 << et), et); end
    end
    fir_dout_valid = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy got %b exp 0", busy); end
  endtask

  task automatic test_enable_low();
    apply_reset();
    en = 1'b1; req_valid = 4'b0011;
    tick(); tick();
    en = 1'b0; req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      fir_dout = 24'(32'h0B0000 + i); fir_dout_valid = (i < 2); #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL en_ready[%0d] got %b exp 0000", i, req_ready); end
      tick();
      n_checks++; if (fir_din_valid !== 1'b0) begin n_fail++; $display("FAIL en_din_valid[%0d] got %b exp 0", i, fir_din_valid); end
      if (i < 2) begin
        n_checks++; if (ch_dout_valid !== 4'(1 << i) || ch_dout !== 24'(32'h0B0000 + i)) begin n_fail++; $display("FAIL en_route[%0d] got %b/%h exp %b/%h", i, ch_dout_valid, ch_dout, 4'(1 << i), 24'(32'h0B0000 + i)); end
      end
    end
    fir_dout_valid = 1'b0; en = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL en_resume_ready got %b exp 0100", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_error_reset();
    apply_reset();
    fir_dout = 24'h055555; fir_dout_valid = 1'b1;
    tick(); fir_dout_valid = 1'b0;
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", tag_err); end
    n_checks++; if (ch_dout_valid !== 4'b0000) begin n_fail++; $display("FAIL err_no_output got %b exp 0000", ch_dout_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy got %b exp 0", busy); end
    tick();
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", tag_err); end
    for (int k = 0; k < 4; k++) req_data[k*24 +: 24] = 24'(32'h0A0A00 + k);
    en = 1'b1; req_valid = 4'b0010; #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL err_ready_ch1 got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0011; fir_dout = 24'h0E0E0E; fir_dout_valid = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL err_ready_ch0 got %b exp 0001", req_ready); end
    tick();
    fir_dout_valid = 1'b0; req_valid = '0;
    n_checks++; if (ch_id !== 2'd1 || ch_dout_valid !== 4'b0010) begin n_fail++; $display("FAIL err_route_ch1 got %0d/%b exp 1/0010", ch_id, ch_dout_valid); end
    n_checks++; if (fir_din !== 24'h0A0A00) begin n_fail++; $display("FAIL err_din_ch0 got %h exp 0a0a00", fir_din); end
    rst_n = 1'b0; #1;
    n_checks++; if (fir_din !== 24'h0 || fir_din_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_din got %h/%b exp 0/0", fir_din, fir_din_valid); end
    n_checks++; if (ch_dout !== 24'h0 || ch_dout_valid !== 4'h0 || ch_id !== 2'd0) begin n_fail++; $display("FAIL midrst_dout got %h/%b/%0d exp 0/0/0", ch_dout, ch_dout_valid, ch_id); end
    n_checks++; if (tag_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got %b/%b exp 0/0", tag_err, busy); end
    rst_n = 1'b1;
    fir_dout = 24'h066666; fir_dout_valid = 1'b1;
    tick(); fir_dout_valid = 1'b0;
    n_checks++; if (tag_err !== 1'b1 || ch_dout_valid !== 4'b0000) begin n_fail++; $display("FAIL postrst_err got %b/%b exp 1/0000", tag_err, ch_dout_valid); end
    req_valid = 4'hF; #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL postrst_ready got %b exp 0001", req_ready); end
    tick(); req_valid = '0;
    n_checks++; if (fir_din_valid !== 1'b1 || fir_din !== 24'h0A0A00) begin n_fail++; $display("FAIL postrst_din got %b/%h exp 1/0a0a00", fir_din_valid, fir_din); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall_and_wrap();
    test_enable_low();
    test_error_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
